snake_body: RTL

//   Owns the snake: head/body segment positions, direction, length and game-over detection on the

---
 rtl/snake_defs.sv | 30 +++
 rtl/snake_seg_match.sv | 23 ++
 rtl/snake_body.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/snake_defs.sv
// Shared snake definitions: grid geometry, direction and state encodings.
// Used by snake_body; prey generator and renderer import the same encodings.
package snake_defs;
    localparam int DEF_H_W      = 5;
    localparam int DEF_V_W      = 5;
    localparam int DEF_H_MAX    = 31;
    localparam int DEF_V_MAX    = 23;
    localparam int DEF_MAX_LEN  = 16;
    localparam int DEF_LEN_W    = 5;
    localparam int DEF_INIT_LEN = 3;
    localparam int DEF_INIT_X   = 8;
    localparam int DEF_INIT_Y   = 12;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_OVER = 1'b1
    } state_e;

    // Opposite directions differ only in bit 1.
    function automatic dir_e dir_opposite(input dir_e d);
        return dir_e'(d ^ 2'd2);
    endfunction
endpackage

// File: rtl/snake_seg_match.sv
// Parallel compare of one grid cell against N stored segments; only
// indices below i_limit take part, so stale entries never match.
module snake_seg_match #(
    parameter int HW = 5,
    parameter int VW = 5,
    parameter int N  = 16,
    parameter int LW = 5
) (
    input  logic [HW-1:0]        i_x,
    input  logic [VW-1:0]        i_y,
    input  logic [N-1:0][HW-1:0] i_segx,
    input  logic [N-1:0][VW-1:0] i_segy,
    input  logic [LW-1:0]        i_limit,
    output logic                 o_hit
);
    logic [N-1:0] w_hit;

    for (genvar g = 0; g < N; g++) begin : g_cmp
        assign w_hit[g] = (i_segx[g] == i_x) && (i_segy[g] == i_y) && (LW'(g) < i_limit);
    end

    assign o_hit = |w_hit;
endmodule

// File: rtl/snake_body.sv
// Snake owner: segment shift register, direction, growth and game-over FSM.
// Define SNAKE_WRAP_EN to wrap at grid edges instead of ending the game.
module snake_body
    import snake_defs::*;
#(
    parameter int H_LOGIC_WIDTH = DEF_H_W,
    parameter int V_LOGIC_WIDTH = DEF_V_W,
    parameter logic [H_LOGIC_WIDTH-1:0] H_LOGIC_MAX = H_LOGIC_WIDTH'(DEF_H_MAX),
    parameter logic [V_LOGIC_WIDTH-1:0] V_LOGIC_MAX = V_LOGIC_WIDTH'(DEF_V_MAX),
    parameter int MAX_LEN   = DEF_MAX_LEN,
    parameter int LEN_WIDTH = DEF_LEN_W,
    parameter int INIT_LEN  = DEF_INIT_LEN,
    parameter int INIT_X    = DEF_INIT_X,
    parameter int INIT_Y    = DEF_INIT_Y
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     step,
    input  logic [1:0]               dir_in,
    input  logic                     restart,
    input  logic [H_LOGIC_WIDTH-1:0] preyx,
    input  logic [V_LOGIC_WIDTH-1:0] preyy,
    input  logic                     prey_vld,
    output logic                     eat,
    output logic [H_LOGIC_WIDTH-1:0] headx,
    output logic [V_LOGIC_WIDTH-1:0] heady,
    output logic [LEN_WIDTH-1:0]     len,
    output logic                     game_over,
    input  logic [H_LOGIC_WIDTH-1:0] qx,
    input  logic [V_LOGIC_WIDTH-1:0] qy,
    output logic                     q_hit
);
    logic [MAX_LEN-1:0][H_LOGIC_WIDTH-1:0] r_segx;
    logic [MAX_LEN-1:0][V_LOGIC_WIDTH-1:0] r_segy;
    logic [LEN_WIDTH-1:0]                  r_len;
    dir_e                                  r_dir;
    state_e                                r_state, w_state_nxt;
    logic                                  r_eat, r_q_hit;

    dir_e                     w_dir;
    logic [H_LOGIC_WIDTH-1:0] w_nx;
    logic [V_LOGIC_WIDTH-1:0] w_ny;
    logic                     w_wall, w_grow, w_collide, w_qhit, w_move, w_load;
    logic [LEN_WIDTH-1:0]     w_limit;

    // Next head position; wall flag only exists in the non-wrapping build.
    always_comb begin
        w_dir  = (dir_e'(dir_in) == dir_opposite(r_dir)) ? r_dir : dir_e'(dir_in);
        w_nx   = r_segx[0];
        w_ny   = r_segy[0];
        w_wall = 1'b0;
        case (w_dir)
            DIR_UP: begin
                if (r_segy[0] == '0) begin
`ifdef SNAKE_WRAP_EN
                    w_ny = V_LOGIC_MAX;
`else
                    w_wall = 1'b1;
`endif
                end else w_ny = r_segy[0] - 1'b1;
            end
            DIR_DOWN: begin
                if (r_segy[0] == V_LOGIC_MAX) begin
`ifdef SNAKE_WRAP_EN
                    w_ny = '0;
`else
                    w_wall = 1'b1;
`endif
                end else w_ny = r_segy[0] + 1'b1;
            end
            DIR_LEFT: begin
                if (r_segx[0] == '0) begin
`ifdef SNAKE_WRAP_EN
                    w_nx = H_LOGIC_MAX;
`else
                    w_wall = 1'b1;
`endif
                end else w_nx = r_segx[0] - 1'b1;
            end
            default: begin
                if (r_segx[0] == H_LOGIC_MAX) begin
`ifdef SNAKE_WRAP_EN
                    w_nx = '0;
`else
                    w_wall = 1'b1;
`endif
                end else w_nx = r_segx[0] + 1'b1;
            end
        endcase
    end

    // The tail vacates its cell on a plain move, so it only blocks when growing.
    assign w_grow  = prey_vld && (w_nx == preyx) && (w_ny == preyy);
    assign w_limit = w_grow ? r_len : r_len - 1'b1;

    snake_seg_match #(.HW(H_LOGIC_WIDTH), .VW(V_LOGIC_WIDTH), .N(MAX_LEN), .LW(LEN_WIDTH)) u_self (
        .i_x(w_nx), .i_y(w_ny), .i_segx(r_segx), .i_segy(r_segy), .i_limit(w_limit), .o_hit(w_collide)
    );

    snake_seg_match #(.HW(H_LOGIC_WIDTH), .VW(V_LOGIC_WIDTH), .N(MAX_LEN), .LW(LEN_WIDTH)) u_query (
        .i_x(qx), .i_y(qy), .i_segx(r_segx), .i_segy(r_segy), .i_limit(r_len), .o_hit(w_qhit)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_move      = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (step) begin
                    if (w_wall || w_collide) w_state_nxt = ST_OVER;
                    else                     w_move      = 1'b1;
                end
            end
            default: begin
                if (restart) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_RUN;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_segx[i] <= H_LOGIC_WIDTH'(INIT_X - i);
                r_segy[i] <= V_LOGIC_WIDTH'(INIT_Y);
            end
            r_len   <= LEN_WIDTH'(INIT_LEN);
            r_dir   <= DIR_RIGHT;
            r_eat   <= 1'b0;
            r_q_hit <= 1'b0;
        end else begin
            r_eat   <= w_move && w_grow;
            r_q_hit <= w_qhit;
            if (w_load) begin
                for (int i = 0; i < MAX_LEN; i++) begin
                    r_segx[i] <= H_LOGIC_WIDTH'(INIT_X - i);
                    r_segy[i] <= V_LOGIC_WIDTH'(INIT_Y);
                end
                r_len <= LEN_WIDTH'(INIT_LEN);
                r_dir <= DIR_RIGHT;
            end else if (w_move) begin
                for (int i = 1; i < MAX_LEN; i++) begin
                    r_segx[i] <= r_segx[i-1];
                    r_segy[i] <= r_segy[i-1];
                end
                r_segx[0] <= w_nx;
                r_segy[0] <= w_ny;
                r_dir     <= w_dir;
                if (w_grow && (r_len < LEN_WIDTH'(MAX_LEN))) r_len <= r_len + 1'b1;
            end
        end
    end

    assign eat       = r_eat;
    assign headx     = r_segx[0];
    assign heady     = r_segy[0];
    assign len       = r_len;
    assign game_over = (r_state == ST_OVER);
    assign q_hit     = r_q_hit;
endmodule
